// File: rtl/riscv_defs_pkg.sv
// Shared core definitions: default widths, the x0 index and a clog2 helper
// used to size register address fields.
package riscv_defs;

    localparam int DEF_XLEN       = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int REG_ZERO       = 0;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: picks stored or same-cycle write data,
// then captures it when enabled and holds it while stalled.
module regfile_rd_port
    import riscv_defs::*;
#(
    parameter int XLEN   = DEF_XLEN,
    parameter int AW     = DEF_REG_ADDR_W,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rd_en,
    input  logic [AW-1:0]       rd_addr,
    input  logic [XLEN-1:0]     cur_data,
    input  logic                cur_busy,
    input  logic                nxt_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    output logic [XLEN-1:0]     rd_data,
    output logic                rd_busy
);

    logic [XLEN-1:0] data_nxt;
    logic            busy_nxt;

    // wr_en arrives already filtered for x0; later ports override earlier ones.
    always_comb begin
        data_nxt = cur_data;
        busy_nxt = cur_busy;
        if (BYPASS != 0) begin
            busy_nxt = nxt_busy;
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr)) begin
                    data_nxt = wr_data[j*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
            rd_busy <= 1'b0;
        end else if (rd_en) begin
            rd_data <= data_nxt;
            rd_busy <= busy_nxt;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register pending bits for
// issue/writeback hazard tracking.
module regfile_mp
    import riscv_defs::*;
#(
    parameter  int XLEN     = DEF_XLEN,
    parameter  int NREGS    = 32,
    parameter  int NRD      = 2,
    parameter  int NWR      = 1,
    parameter  int BYPASS   = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pend_nxt;
    logic [NWR-1:0]   wr_ok;
    logic             set_ok;

    // x0 filtering happens once here so storage, scoreboard and bypass agree.
    always_comb begin
        wr_ok = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_ok[j] = wr_en[j] &&
                       !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == AW'(REG_ZERO)));
        end
        set_ok = set_en && !((ZERO_REG != 0) && (set_addr == AW'(REG_ZERO)));
    end

    // Set is applied after clears: a new producer issued in the retire cycle stays pending.
    always_comb begin
        pend_nxt = pending;
        for (int j = 0; j < NWR; j++) begin
            if (wr_ok[j]) begin
                pend_nxt[wr_addr[j*AW +: AW]] = 1'b0;
            end
        end
        if (set_ok) begin
            pend_nxt[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            pending <= '0;
        end else begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_ok[j]) begin
                    mem[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
                end
            end
            pending <= pend_nxt;
        end
    end

    assign busy_vec = pending;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regfile_rd_port #(
            .XLEN   (XLEN),
            .AW     (AW),
            .NWR    (NWR),
            .BYPASS (BYPASS)
        ) u_rd_port (
            .clk      (clk),
            .rst_n    (rst_n),
            .rd_en    (rd_en[k]),
            .rd_addr  (rd_addr[k*AW +: AW]),
            .cur_data (mem[rd_addr[k*AW +: AW]]),
            .cur_busy (pending[rd_addr[k*AW +: AW]]),
            .nxt_busy (pend_nxt[rd_addr[k*AW +: AW]]),
            .wr_en    (wr_ok),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[k*XLEN +: XLEN]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule
